// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Key index layout is {col, row}; KEY_MAP follows the PmodKYPD legend.
package keypad_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;

  typedef logic [3:0] key_idx_t;

  typedef struct packed {
    logic     hit;
    key_idx_t idx;
    logic     multi;
  } frame_res_t;

  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce and key acceptance for keypad_scan.
// Auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_FRAMES    = 3,
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_end_i,
  input  frame_res_t res_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_down_o,
  output logic       multi_o
);

  localparam logic [3:0] DebMax = 4'(DEB_FRAMES);

  frame_res_t prev_q, prev_d;
  logic [3:0] stable_q, stable_d;
  logic [3:0] code_q, code_d;
  key_idx_t   idx_q, idx_d;
  logic       down_q, down_d, multi_q, multi_d, valid_q, valid_d;
  logic       same, accept, accept_new;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_FRAMES + 1);
  logic [RepW-1:0] rep_q, rep_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q   <= '0;
      stable_q <= '0;
      code_q   <= '0;
      idx_q    <= '0;
      down_q   <= 1'b0;
      multi_q  <= 1'b0;
      valid_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      down_q   <= down_d;
      multi_q  <= multi_d;
      valid_q  <= valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  always_comb begin
    prev_d     = prev_q;
    stable_d   = stable_q;
    code_d     = code_q;
    idx_d      = idx_q;
    down_d     = down_q;
    multi_d    = multi_q;
    valid_d    = 1'b0;
    same       = (res_i == prev_q);
    accept     = 1'b0;
    accept_new = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d      = rep_q;
`endif
    if (frame_end_i) begin
      prev_d = res_i;
      if (!same) begin
        stable_d = 4'd1;
      end else if (stable_q != DebMax) begin
        stable_d = stable_q + 4'd1;
      end
      // Act only on the frame where the count first reaches the threshold.
      accept = (stable_d == DebMax) && !(same && stable_q == DebMax);
      if (accept) begin
        if (res_i.hit) begin
          multi_d = res_i.multi;
          if (!down_q || res_i.idx != idx_q) begin
            accept_new = 1'b1;
            code_d     = KEY_MAP[res_i.idx];
            idx_d      = res_i.idx;
            down_d     = 1'b1;
            valid_d    = 1'b1;
          end
        end else begin
          down_d  = 1'b0;
          multi_d = 1'b0;
        end
      end
`ifdef KEYPAD_REPEAT_EN
      if (accept_new) begin
        rep_d = '0;
      end else if (down_q && same && res_i.hit && res_i.idx == idx_q && stable_q == DebMax) begin
        if (rep_q == RepW'(REPEAT_FRAMES - 1)) begin
          rep_d   = '0;
          valid_d = 1'b1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end else begin
        rep_d = '0;
      end
`endif
    end
  end

  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_down_o  = down_q;
  assign multi_o     = multi_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with row synchronizer and per-frame hit accumulator.
// Define KEYPAD_REPEAT_EN to enable auto-repeat in keypad_debounce.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_N        = 2,
  parameter int unsigned DEB_FRAMES    = 3,
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       multi
);

  if (SCAN_N < 2 || DEB_FRAMES == 0 || DEB_FRAMES > 15 || REPEAT_FRAMES == 0) begin : g_bad_param
    $error("keypad_scan: illegal parameter value");
  end

  logic [SCAN_N+1:0] cnt_q;
  logic [1:0]        col, first_row;
  logic              sample, frame_end;
  logic [3:0]        row_meta_q, row_sync_q, hits;
  frame_res_t        acc_q, base, merged;

  assign col       = cnt_q[SCAN_N +: 2];
  assign col_n     = ~(4'b0001 << col);
  assign sample    = &cnt_q[SCAN_N-1:0];
  assign frame_end = sample && (col == 2'd3);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q      <= '0;
      row_meta_q <= '1;
      row_sync_q <= '1;
      acc_q      <= '0;
    end else begin
      cnt_q      <= cnt_q + 1'b1;
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      if (sample) acc_q <= merged;
    end
  end

  // Merge this column's hits into the frame; column 0 starts a fresh frame.
  always_comb begin
    base      = (col == 2'd0) ? frame_res_t'('0) : acc_q;
    hits      = ~row_sync_q;
    merged    = base;
    first_row = 2'd0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (hits[r]) first_row = 2'(r);
    end
    if (hits != 4'b0000) begin
      if (base.hit) begin
        merged.multi = 1'b1;
      end else begin
        merged.hit   = 1'b1;
        merged.idx   = {col, first_row};
        merged.multi = ((hits & (hits - 4'd1)) != 4'b0000);
      end
    end
  end

  keypad_debounce #(
    .DEB_FRAMES    (DEB_FRAMES),
    .REPEAT_FRAMES (REPEAT_FRAMES)
  ) u_debounce (
    .clk_i       (Clk),
    .reset_i     (Reset),
    .frame_end_i (frame_end),
    .res_i       (merged),
    .key_code_o  (key_code),
    .key_valid_o (key_valid),
    .key_down_o  (key_down),
    .multi_o     (multi)
  );

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scanning receiver for a 4x4 matrix keypad (PmodKYPD-style) on the BASYS3 board with a 100 MHz clock.
- Input-side counterpart of the multiplexed-display anode scanner: it drives one active-low column at a time and samples the active-low rows.
- It debounces whole scan frames and emits a one-cycle key_valid strobe with a hex key code.
- Sits beside the display path; key codes feed the digit registers and control logic.

Parameters:
- SCAN_N, 2, each column is held for 2**SCAN_N clocks. Use 2 for simulation and 18 for implementation. Legal range is 2 or more.
- DEB_FRAMES, 3, number of consecutive identical frame results required to accept a change. Legal range is 1 to 15.
- REPEAT_FRAMES, 8, auto-repeat interval in frames. Used only with the optional feature.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- row_n  in  4  keypad rows, active-low, asynchronous to Clk
- col_n  out  4  keypad columns, active-low, exactly one bit low at all times
- key_code  out  4  hex value of the accepted key
- key_valid  out  1  one-cycle strobe when a new key is accepted
- key_down  out  1  level output: a debounced key is currently held
- multi  out  1  level output: the debounced frame saw more than one key

Behaviour:
- Interface: one clock (Clk); reset (Reset) is synchronous and active-high.
- Scan counter (SCAN_N+2 bits):
  - Increments every clock and wraps freely.
  - col = top 2 bits; col_n = ~(1 << col), decoded combinationally from the counter.
- row_n passes through a 2-flop synchronizer, reset value 4'b1111.
- Sample point: the cycle when the low SCAN_N counter bits are all ones, i.e. the last clock of the column window. This gives at least 2 settle clocks.
- Frame accumulator:
  - Clears at col 0 sample time, before merging.
  - Per sample, take hit rows where synchronized row = 0.
  - The first hit in scan order (col ascending, then row ascending) records idx = {col,row}.
  - Any additional hit in the frame sets fmulti.
- Frame end is the col-3 sample. At frame end, result R = (hit, idx, fmulti) is compared with the previous frame's result:
  - If equal, stable_cnt increments, saturating at DEB_FRAMES.
  - If different, stable_cnt = 1.
- Acceptance: on the cycle stable_cnt first reaches DEB_FRAMES:
  - R.hit and (key_down==0 or idx != current idx):
    - key_code = KEY_MAP[idx], multi = fmulti, key_down = 1.
    - key_valid pulses on the next cycle, for exactly 1 clock.
  - R.hit with the same idx: update multi only; no pulse.
  - !R.hit: key_down = 0, multi = 0; key_code holds its value; no pulse.
- Latency: a press held steady from the start of frame k is accepted at the end of frame k+DEB_FRAMES-1. With SCAN_N=2, a frame is 16 clocks.
- Direct key change A to B: a new pulse occurs after B is stable; key_down stays 1 throughout.
- Reset values:
  - counter 0, so col_n = 4'b1110.
  - key_code 0, key_valid 0, key_down 0, multi 0.
  - stable_cnt 0, previous result = no-hit.
- Reset mid-frame or mid-press: the partial frame is discarded. A held key is re-accepted after DEB_FRAMES full frames, producing a new pulse.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - While key_down is set and the same idx remains stable, key_valid re-pulses every REPEAT_FRAMES frame-ends after acceptance.
  - The repeat counter clears on any change or release.
- Undefined: exactly one pulse per accepted press; no repeat logic is present.

Decomposition:
- Package keypad_pkg holds:
  - NUM_COLS=4 and NUM_ROWS=4.
  - typedef key_idx_t (logic [3:0], {col,row}).
  - Constant KEY_MAP[16] for the PmodKYPD layout:
    - col0 rows 0..3 = 1,4,7,0
    - col1 = 2,5,8,F
    - col2 = 3,6,9,E
    - col3 = A,B,C,D
- One sub-module, keypad_debounce: frame-result compare, stable_cnt, acceptance, and the repeat logic.
- Scan counter, synchronizer and frame accumulator stay in keypad_scan.

Test Plan:
- Reset asserted 3 clocks -> col_n=1110, all outputs 0; first sample at the 4th clock after release; col_n steps 1110,1101,1011,0111 every 4 clocks.
- Keypad model closes col1/row1 from frame 0 -> single key_valid with key_code=4'h5, key_down=1, one cycle after the frame-2 end. Release -> key_down=0 after 3 frames, no pulse.
- Key 8 bounces (pressed, released, pressed in alternate frames) for 4 frames, then held -> no pulse during bounce; exactly one pulse with code 8 after 3 stable frames.
- Keys 1 (col0,row0) and D (col3,row3) held together -> key_code=1, multi=1. Release D only -> multi=0 after 3 frames, no new pulse.
- Key 6 accepted, Reset pulsed mid-frame while still held -> outputs 0; new pulse with code 6 after 3 full frames.
- KEYPAD_REPEAT_EN defined, REPEAT_FRAMES=8, key A held 20 frames -> pulses at acceptance, +8 frames, +16 frames (3 total). Macro undefined -> 1 pulse.
